// File: rtl/ram_lsu_master_pkg.sv
// rtl/ram_lsu_master_pkg.sv - shared types and defaults for the RAM load/store initiator
package ram_lsu_master_pkg;

    localparam int          DEFAULT_RAM_ADDR_WIDTH = 8;
    localparam logic [31:0] DEFAULT_RAM_BASE       = 32'h0000_1000;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10,
        MEM_X = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC1 = 2'b01,
        ACC2 = 2'b10,
        RESP = 2'b11
    } st_lsu_t;

    // Access width in bytes; the illegal encoding is treated as a word so the
    // split calculation stays well defined (the request is faulted anyway).
    function automatic logic [2:0] size_bytes(input mem_size_t s);
        case (s)
            MEM_B:   return 3'd1;
            MEM_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_lsu_master_lane_align.sv
// rtl/ram_lsu_master_lane_align.sv - byte-lane steering for stores and load extraction/extension
//
// Purely combinational.
//   offset        byte offset of the access within its first word
//   size          access width (B/H/W)
//   wdata         right-justified store data
//   rdata_pair    {high word, low word} as read from the RAM
//   is_unsigned   zero-extend (1) or sign-extend (0) load results
//   strobe        8-bit lane mask across both words ([3:0] first word, [7:4] second)
//   wdata_shifted store data moved onto its lanes across both words
//   rdata_ext     load result, right-justified and extended to 32 bits
module lsu_lane_align
    import ram_lsu_master_pkg::*;
(
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata_pair,
    input  logic        is_unsigned,
    output logic [7:0]  strobe,
    output logic [63:0] wdata_shifted,
    output logic [31:0] rdata_ext
);

    logic [3:0]  mask4;
    logic [63:0] rd_shifted;

    always_comb begin
        case (size)
            MEM_B:   mask4 = 4'b0001;
            MEM_H:   mask4 = 4'b0011;
            default: mask4 = 4'b1111;
        endcase

        strobe        = {4'b0000, mask4} << offset;
        wdata_shifted = {32'h0, wdata} << {offset, 3'b000};
        rd_shifted    = rdata_pair >> {offset, 3'b000};

        case (size)
            MEM_B:   rdata_ext = {{24{~is_unsigned & rd_shifted[7]}},  rd_shifted[7:0]};
            MEM_H:   rdata_ext = {{16{~is_unsigned & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rdata_ext = rd_shifted[31:0];
        endcase
    end

endmodule

// File: rtl/ram_lsu_master.sv
// rtl/ram_lsu_master.sv - byte-addressed load/store initiator for a word-addressed, byte-strobed RAM
//
// Ports:
//   clk, rst                        clock; synchronous active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE, out of reset)
//   req_we/addr/size/unsigned/wdata request fields, sampled at accept
//   rsp_valid/rsp_rdata/rsp_err     one-cycle response per accepted request
//   ram_rd_en/wr_en/addr            RAM control (word address)
//   ram_wr_data/ram_wr_strobe       lane-shifted store data and byte strobes
//   ram_rd_data                     combinational RAM read data
module ram_lsu_master
    import ram_lsu_master_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_RAM_BASE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_rd_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wr_data,
    output logic [3:0]            ram_wr_strobe,
    input  logic [31:0]           ram_rd_data
);

    localparam logic [32:0]           SPAN      = 33'd4 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_WIDX = '1;

    st_lsu_t state, state_nxt;

    // Request decode, evaluated on the live request fields in IDLE.
    logic [31:0]           req_off;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] widx_in;
    logic [2:0]            nbytes_in;
    logic                  split_in;
    logic                  err_in;

    always_comb begin
        req_off   = req_addr - BASE_ADDR;
        // 33-bit compare so a RAM ending at 2**32 does not wrap.
        in_range  = (req_addr >= BASE_ADDR) && ({1'b0, req_off} < SPAN);
        widx_in   = req_off[ADDR_WIDTH+1:2];
        nbytes_in = size_bytes(mem_size_t'(req_size));
        split_in  = ({1'b0, req_addr[1:0]} + nbytes_in) > 3'd4;
        // A split that would need the word after the last one is a fault, not a wrap.
        err_in    = (req_size == 2'b11) || !in_range || (split_in && (widx_in == LAST_WIDX));
    end

    // Registered request.
    logic                  we_q;
    logic [1:0]            off_q;
    mem_size_t             size_q;
    logic                  uns_q;
    logic [31:0]           wdata_q;
    logic [ADDR_WIDTH-1:0] widx_q;
    logic                  split_q;
    logic                  err_q;
    logic [31:0]           lo_q;
    logic [31:0]           hi_q;

    logic [7:0]  strobe8;
    logic [63:0] wdata64;
    logic [31:0] rdata_ext;

    lsu_lane_align u_align (
        .offset        (off_q),
        .size          (size_q),
        .wdata         (wdata_q),
        .rdata_pair    ({hi_q, lo_q}),
        .is_unsigned   (uns_q),
        .strobe        (strobe8),
        .wdata_shifted (wdata64),
        .rdata_ext     (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            off_q   <= 2'b00;
            size_q  <= MEM_B;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            widx_q  <= '0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                off_q   <= req_addr[1:0];
                size_q  <= mem_size_t'(req_size);
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                widx_q  <= widx_in;
                split_q <= split_in;
                err_q   <= err_in;
            end
            if (state == ACC1 && !we_q) lo_q <= ram_rd_data;
            if (state == ACC2 && !we_q) hi_q <= ram_rd_data;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_err       = 1'b0;
        rsp_rdata     = 32'h0;
        ram_rd_en     = 1'b0;
        ram_wr_en     = 1'b0;
        ram_addr      = widx_q;
        ram_wr_data   = 32'h0;
        ram_wr_strobe = 4'b0000;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = err_in ? RESP : ACC1;
            end
            ACC1: begin
                ram_rd_en     = ~we_q;
                ram_wr_en     = we_q;
                ram_wr_strobe = we_q ? strobe8[3:0] : 4'b0000;
                ram_wr_data   = we_q ? wdata64[31:0] : 32'h0;
                state_nxt     = split_q ? ACC2 : RESP;
            end
            ACC2: begin
                ram_addr      = widx_q + ADDR_WIDTH'(1);
                ram_rd_en     = ~we_q;
                ram_wr_en     = we_q;
                ram_wr_strobe = we_q ? strobe8[7:4] : 4'b0000;
                ram_wr_data   = we_q ? wdata64[63:32] : 32'h0;
                state_nxt     = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (we_q || err_q) ? 32'h0 : rdata_ext;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Reset silences the RAM and response immediately, not just from the next edge.
        if (rst) begin
            req_ready     = 1'b0;
            rsp_valid     = 1'b0;
            rsp_err       = 1'b0;
            rsp_rdata     = 32'h0;
            ram_rd_en     = 1'b0;
            ram_wr_en     = 1'b0;
            ram_wr_data   = 32'h0;
            ram_wr_strobe = 4'b0000;
        end
    end

endmodule

// File: tb/tb_ram_lsu_master.sv
// tb/tb_ram_lsu_master.sv - self-checking bench for ram_lsu_master
module tb_ram_lsu_master;
    import ram_lsu_master_pkg::*;

    localparam int          AW     = DEFAULT_RAM_ADDR_WIDTH;
    localparam logic [31:0] BASE   = DEFAULT_RAM_BASE;
    localparam int          NBYTES = 4 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = 32'h0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_wdata = 32'h0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_rd_en;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wr_data;
    logic [3:0]    ram_wr_strobe;
    logic [31:0]   ram_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:NBYTES-1];
    logic [7:0] sb  [0:NBYTES-1];

    always #5 clk = ~clk;

    ram_lsu_master dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .ram_rd_en     (ram_rd_en),
        .ram_wr_en     (ram_wr_en),
        .ram_addr      (ram_addr),
        .ram_wr_data   (ram_wr_data),
        .ram_wr_strobe (ram_wr_strobe),
        .ram_rd_data   (ram_rd_data)
    );

    // RAM model: combinational read, byte-strobed write; filled with a known pattern on reset
    // only before the first release so later resets keep content.
    logic mem_loaded = 1'b0;
    assign ram_rd_data = {mem[{ram_addr, 2'd3}], mem[{ram_addr, 2'd2}],
                          mem[{ram_addr, 2'd1}], mem[{ram_addr, 2'd0}]};
    always @(posedge clk) begin
        if (rst && !mem_loaded) begin
            for (int i = 0; i < NBYTES; i++) mem[i] <= 8'((i * 7 + 3) & 255);
        end else begin
            mem_loaded <= 1'b1;
            if (ram_wr_en)
                for (int i = 0; i < 4; i++)
                    if (ram_wr_strobe[i]) mem[{ram_addr, 2'(i)}] <= ram_wr_data[8*i +: 8];
        end
    end

    // Observations of the last request issued by do_req.
    logic [31:0]   obs_rdata;
    logic          obs_err;
    int            obs_lat;
    int            obs_nacc;
    logic [AW-1:0] obs_addr  [2];
    logic [3:0]    obs_strb  [2];
    logic [31:0]   obs_wdata [2];
    logic          obs_wr    [2];

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata);
        int w;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        @(posedge clk);
        obs_lat = 99; obs_nacc = 0; obs_err = 1'bx; obs_rdata = 32'hBAD0BAD0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (ram_rd_en || ram_wr_en) begin
                if (obs_nacc < 2) begin
                    obs_addr[obs_nacc]  = ram_addr;
                    obs_strb[obs_nacc]  = ram_wr_strobe;
                    obs_wdata[obs_nacc] = ram_wr_data;
                    obs_wr[obs_nacc]    = ram_wr_en;
                end
                obs_nacc++;
            end
            if (rsp_valid) begin
                obs_lat   = c;
                obs_rdata = rsp_rdata;
                obs_err   = rsp_err;
                break;
            end
        end
    endtask

    function automatic logic [31:0] model_load(input int a, input logic [1:0] sz, input logic uns);
        int n;
        logic [31:0] v;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = sb[a + i];
        if (!uns && n == 1 && v[7])  v[31:8]  = '1;
        if (!uns && n == 2 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs ready=%b valid=%b err=%b rdata=%h exp 0/0/0/0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        n_checks++;
        if (ram_rd_en !== 1'b0 || ram_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_enables rd=%b wr=%b exp 0/0", ram_rd_en, ram_wr_en);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got %b exp 1", req_ready);
        end
    endtask

    task automatic test_aligned_word();
        do_req(1'b1, BASE + 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        n_checks++;
        if (obs_nacc !== 1 || obs_addr[0] !== AW'(4) || obs_strb[0] !== 4'b1111 ||
            obs_wdata[0] !== 32'hDEADBEEF || obs_wr[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_aligned_access nacc=%0d addr=%h strb=%b wdata=%h exp 1/04/1111/deadbeef",
                     obs_nacc, obs_addr[0], obs_strb[0], obs_wdata[0]);
        end
        n_checks++;
        if (obs_lat !== 2 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL sw_aligned_rsp lat=%0d err=%b rdata=%h exp 2/0/0", obs_lat, obs_err, obs_rdata);
        end
        do_req(1'b0, BASE + 32'h10, 2'b10, 1'b0, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'hDEADBEEF || obs_lat !== 2 || obs_nacc !== 1) begin
            n_fail++;
            $display("FAIL lw_aligned rdata=%h lat=%0d nacc=%0d exp deadbeef/2/1", obs_rdata, obs_lat, obs_nacc);
        end
    endtask

    task automatic test_byte();
        do_req(1'b1, BASE + 32'h13, 2'b00, 1'b0, 32'h00000080);
        n_checks++;
        if (obs_addr[0] !== AW'(4) || obs_strb[0] !== 4'b1000 || obs_wdata[0] !== 32'h80000000) begin
            n_fail++;
            $display("FAIL sb_lanes addr=%h strb=%b wdata=%h exp 04/1000/80000000",
                     obs_addr[0], obs_strb[0], obs_wdata[0]);
        end
        do_req(1'b0, BASE + 32'h13, 2'b00, 1'b0, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'hFFFFFF80) begin
            n_fail++;
            $display("FAIL lb_signed got %h exp ffffff80", obs_rdata);
        end
        do_req(1'b0, BASE + 32'h13, 2'b00, 1'b1, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'h00000080) begin
            n_fail++;
            $display("FAIL lbu got %h exp 00000080", obs_rdata);
        end
    endtask

    task automatic test_split();
        do_req(1'b1, BASE + 32'h22, 2'b10, 1'b0, 32'h11223344);
        n_checks++;
        if (obs_nacc !== 2 || obs_addr[0] !== AW'(8) || obs_strb[0] !== 4'b1100 ||
            obs_wdata[0] !== 32'h33440000) begin
            n_fail++;
            $display("FAIL sw_split_acc1 nacc=%0d addr=%h strb=%b wdata=%h exp 2/08/1100/33440000",
                     obs_nacc, obs_addr[0], obs_strb[0], obs_wdata[0]);
        end
        n_checks++;
        if (obs_addr[1] !== AW'(9) || obs_strb[1] !== 4'b0011 || obs_wdata[1] !== 32'h00001122 ||
            obs_lat !== 3) begin
            n_fail++;
            $display("FAIL sw_split_acc2 addr=%h strb=%b wdata=%h lat=%0d exp 09/0011/00001122/3",
                     obs_addr[1], obs_strb[1], obs_wdata[1], obs_lat);
        end
        do_req(1'b0, BASE + 32'h22, 2'b10, 1'b0, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'h11223344 || obs_lat !== 3) begin
            n_fail++;
            $display("FAIL lw_split rdata=%h lat=%0d exp 11223344/3", obs_rdata, obs_lat);
        end
        do_req(1'b0, BASE + 32'h23, 2'b01, 1'b0, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'h00002233 || obs_lat !== 3) begin
            n_fail++;
            $display("FAIL lh_split rdata=%h lat=%0d exp 00002233/3", obs_rdata, obs_lat);
        end
        // 0x13 holds 0x80 (byte store above), 0x14 still holds pattern byte 0x8f.
        do_req(1'b0, BASE + 32'h13, 2'b01, 1'b0, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'hFFFF8F80) begin
            n_fail++;
            $display("FAIL lh_split_signed got %h exp ffff8f80", obs_rdata);
        end
        do_req(1'b0, BASE + 32'h3FF, 2'b00, 1'b0, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'hFFFFFFFC || obs_err !== 1'b0 || obs_lat !== 2) begin
            n_fail++;
            $display("FAIL lb_last_byte rdata=%h err=%b lat=%0d exp fffffffc/0/2", obs_rdata, obs_err, obs_lat);
        end
    endtask

    task automatic test_faults();
        logic        f_we   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] f_addr [5] = '{BASE - 32'd4, BASE, BASE + 32'h3FF, BASE + 32'h400, BASE - 32'd4};
        logic [1:0]  f_size [5] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b10};
        for (int k = 0; k < 5; k++) begin
            do_req(f_we[k], f_addr[k], f_size[k], 1'b0, 32'hFFFFFFFF);
            n_checks++;
            if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_lat !== 1 || obs_nacc !== 0) begin
                n_fail++;
                $display("FAIL fault_%0d err=%b rdata=%h lat=%0d nacc=%0d exp 1/0/1/0",
                         k, obs_err, obs_rdata, obs_lat, obs_nacc);
            end
        end
    endtask

    task automatic test_reset_mid_split();
        bit stray;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h42; req_size = 2'b10;
        req_unsigned = 1'b0; req_wdata = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (ram_wr_en !== 1'b1 || ram_addr !== AW'(8'h10)) begin
            n_fail++;
            $display("FAIL rst_split_acc1 wr=%b addr=%h exp 1/10", ram_wr_en, ram_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_split_during wr=%b rd=%b valid=%b exp 0/0/0", ram_wr_en, ram_rd_en, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_split_idle ready=%b valid=%b exp 1/0", req_ready, rsp_valid);
        end
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_split_no_rsp got %b exp 0", stray);
        end
        do_req(1'b0, BASE + 32'h40, 2'b10, 1'b0, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'h3344CAC3 || obs_lat !== 2) begin
            n_fail++;
            $display("FAIL rst_split_word1 rdata=%h lat=%0d exp 3344cac3/2", obs_rdata, obs_lat);
        end
        do_req(1'b0, BASE + 32'h44, 2'b10, 1'b0, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'hF4EDE6DF) begin
            n_fail++;
            $display("FAIL rst_split_word2 got %h exp f4ede6df", obs_rdata);
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [11:0] off;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] wd;
    } vec_t;

    task automatic test_back_to_back();
        vec_t        v [14];
        int          w, lat, exp_lat, a, n, rsp_seen;
        bit          ready_busy;
        logic [31:0] exp;
        v = '{
            '{1'b1, 12'h200, 2'b10, 1'b0, 32'hA1B2C3D4},
            '{1'b0, 12'h200, 2'b10, 1'b0, 32'h0},
            '{1'b1, 12'h203, 2'b01, 1'b0, 32'h00008765},
            '{1'b0, 12'h203, 2'b01, 1'b0, 32'h0},
            '{1'b0, 12'h203, 2'b01, 1'b1, 32'h0},
            '{1'b1, 12'h206, 2'b00, 1'b0, 32'h0000007F},
            '{1'b0, 12'h206, 2'b00, 1'b0, 32'h0},
            '{1'b0, 12'h201, 2'b10, 1'b0, 32'h0},
            '{1'b1, 12'h207, 2'b10, 1'b0, 32'hCAFEF00D},
            '{1'b0, 12'h208, 2'b10, 1'b0, 32'h0},
            '{1'b0, 12'h207, 2'b00, 1'b1, 32'h0},
            '{1'b0, 12'h20A, 2'b00, 1'b0, 32'h0},
            '{1'b1, 12'h209, 2'b01, 1'b0, 32'h0000F1E2},
            '{1'b0, 12'h206, 2'b10, 1'b0, 32'h0}
        };
        rsp_seen = 0;
        @(negedge clk);
        req_valid = 1'b1;
        for (int k = 0; k < 14; k++) begin
            w = 0;
            while (!req_ready && w < 10) begin
                @(negedge clk);
                w++;
            end
            a = int'(v[k].off);
            n = (v[k].sz == 2'b00) ? 1 : (v[k].sz == 2'b01) ? 2 : 4;
            exp_lat = ((a % 4) + n > 4) ? 3 : 2;
            if (v[k].we) begin
                for (int i = 0; i < n; i++) sb[a + i] = v[k].wd[8*i +: 8];
                exp = 32'h0;
            end else begin
                exp = model_load(a, v[k].sz, v[k].uns);
            end
            req_we = v[k].we; req_addr = BASE + 32'(a); req_size = v[k].sz;
            req_unsigned = v[k].uns; req_wdata = v[k].wd;
            @(posedge clk);
            lat = 99; ready_busy = 1'b0; obs_rdata = 32'hBAD0BAD0; obs_err = 1'bx;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (req_ready) ready_busy = 1'b1;
                if (rsp_valid) begin
                    lat = c; obs_rdata = rsp_rdata; obs_err = rsp_err; rsp_seen++;
                    break;
                end
            end
            n_checks++;
            if (obs_rdata !== exp || obs_err !== 1'b0 || lat !== exp_lat || ready_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_%0d rdata=%h err=%b lat=%0d ready_busy=%b exp %h/0/%0d/0",
                         k, obs_rdata, obs_err, lat, ready_busy, exp, exp_lat);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        n_checks++;
        if (rsp_seen !== 14) begin
            n_fail++;
            $display("FAIL stream_rsp_count got %0d exp 14", rsp_seen);
        end
    endtask

    initial begin
        for (int i = 0; i < NBYTES; i++) sb[i] = 8'((i * 7 + 3) & 255);
        test_reset();
        test_aligned_word();
        test_byte();
        test_split();
        test_faults();
        test_reset_mid_split();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
